y86_dmem_requester: RTL

- Initiator side of the Y86 data-memory interface: takes the memory-stage command (icode, valA, valE, valP) and issues one read or write over a valid/ready request channel.
- Waits for the response, returns valM and dmem_error, and pulses done.
- Sits between execute/memory stage control and a multi-cycle data memory, replacing the zero-latency array access.

---
 rtl/y86_dmem_requester.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/y86_dmem_requester.sv
// Initiator side of the Y86 data-memory interface: decodes a memory-stage command and issues
// one read or write over a valid/ready channel. Optional abort timer: Y86_DMEM_TIMEOUT_EN.
module y86_dmem_requester #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned MEM_LIMIT      = 1023,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StFin} state_e;

  localparam logic [ADDR_W-1:0] Limit = ADDR_W'(MEM_LIMIT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              req_valid_q, req_valid_d;
  logic              timeout;

  logic              dec_acc;
  logic              dec_we;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wdata;

  always_comb begin
    dec_acc   = 1'b1;
    dec_we    = 1'b0;
    dec_addr  = valE;
    dec_wdata = valA;
    case (icode)
      4'h4:        dec_we = 1'b1;
      4'h5:        dec_we = 1'b0;
      4'h8: begin
        dec_we    = 1'b1;
        dec_wdata = valP;
      end
      4'h9, 4'hB:  dec_addr = ADDR_W'(valA);
      4'hA:        dec_we = 1'b1;
      default:     dec_acc = 1'b0;
    endcase
  end

`ifdef Y86_DMEM_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  // Counter spans REQ and RSP; >= covers a handshake that lands on the final count.
  assign timeout = (cnt_q >= TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    valm_d      = valm_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    we_d        = we_q;
    err_d       = err_q;
    req_valid_d = req_valid_q;
`ifdef Y86_DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (!dec_acc) begin
            state_d = StFin;
          end else if (dec_addr > Limit) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            we_d        = dec_we;
            addr_d      = dec_addr;
            wdata_d     = dec_wdata;
            req_valid_d = 1'b1;
            state_d     = StReq;
`ifdef Y86_DMEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = StRsp;
        end else if (timeout) begin
          req_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = StFin;
        end
`ifdef Y86_DMEM_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
      end
      StRsp: begin
        if (mem_rsp_valid) begin
          if (!we_q) valm_d = mem_rsp_rdata;
          err_d   = mem_rsp_err;
          state_d = StFin;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
`ifdef Y86_DMEM_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valm_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
`ifdef Y86_DMEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valm_q      <= valm_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
`ifdef Y86_DMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy          = (state_q == StReq) || (state_q == StRsp);
  assign done          = (state_q == StFin);
  assign valM          = valm_q;
  assign dmem_error    = err_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule
